// File: rtl/pipe_hazard_ctrl.sv
// Hazard and flush sequencer for the 5-stage pipeline: load-use stalls,
// branch/jump redirect flushes and memory-wait freezes, plus debug counters.
module pipe_hazard_ctrl #(
  parameter int LU_STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES    = 1,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             ex_redirect,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic             pipe_freeze,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic [3:0] STALL_LOAD = 4'((LU_STALL_CYCLES > 1) ? (LU_STALL_CYCLES - 2) : 0);
  localparam int         EV_STALL   = 0;
  localparam int         EV_FLUSH   = 1;

  state_t                  state_reg, state_next;
  logic [3:0]              cnt_reg, cnt_next;
  logic                    ifid_flush_reg;
  logic [1:0][CNT_W-1:0]   ev_cnt_reg;
  logic [1:0]              ev_inc;
  logic                    lu_hazard;

  assign lu_hazard = ex_mem_read & (ex_rt != 5'd0) &
                     ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

  // Priority: reset, freeze, redirect, then whatever the current state owes.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    pipe_freeze = 1'b0;
    ev_inc      = 2'b00;
    if (rst) begin
      state_next = RUN;
      cnt_next   = 4'd0;
    end else if (!dmem_ready) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      pipe_freeze = 1'b1;
    end else if (ex_redirect) begin
      idex_bubble      = 1'b1;
      state_next       = FLUSH;
      cnt_next         = FLUSH_LOAD;
      ev_inc[EV_FLUSH] = 1'b1;
    end else begin
      case (state_reg)
        FLUSH: begin
          idex_bubble = 1'b1;
          if (cnt_reg == 4'd0) state_next = RUN;
          else                 cnt_next   = cnt_reg - 4'd1;
        end
        STALL: begin
          pc_write         = 1'b0;
          ifid_write       = 1'b0;
          idex_bubble      = 1'b1;
          ev_inc[EV_STALL] = 1'b1;
          if (cnt_reg == 4'd0) state_next = RUN;
          else                 cnt_next   = cnt_reg - 4'd1;
        end
        default: begin
          if (lu_hazard) begin
            pc_write         = 1'b0;
            ifid_write       = 1'b0;
            idex_bubble      = 1'b1;
            ev_inc[EV_STALL] = 1'b1;
            if (LU_STALL_CYCLES > 1) begin
              state_next = STALL;
              cnt_next   = STALL_LOAD;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= RUN;
      cnt_reg        <= 4'd0;
      ifid_flush_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      ifid_flush_reg <= (state_next == FLUSH);
    end
  end

  // Event counters stick at all-ones so a long debug run never wraps to small values.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst)
        ev_cnt_reg[i] <= '0;
      else if (ev_inc[i] && !(&ev_cnt_reg[i]))
        ev_cnt_reg[i] <= ev_cnt_reg[i] + 1'b1;
    end
  end

  assign ifid_flush = ifid_flush_reg;
  assign stall_cnt  = ev_cnt_reg[EV_STALL];
  assign flush_cnt  = ev_cnt_reg[EV_FLUSH];

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (1-cycle and 3-cycle load-use stalls)
// checked every cycle against a cycle-debt model, plus hand-computed literal checks.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, ex_mem_read, ex_redirect, dmem_ready;

  logic        pc_a, ifw_a, bub_a, flu_a, frz_a;
  logic [15:0] sc_a, fc_a;
  logic        pc_b, ifw_b, bub_b, flu_b, frz_b;
  logic [3:0]  sc_b, fc_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.LU_STALL_CYCLES(1), .FLUSH_CYCLES(2), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_redirect(ex_redirect),
    .dmem_ready(dmem_ready), .pc_write(pc_a), .ifid_write(ifw_a),
    .idex_bubble(bub_a), .ifid_flush(flu_a), .pipe_freeze(frz_a),
    .stall_cnt(sc_a), .flush_cnt(fc_a));

  pipe_hazard_ctrl #(.LU_STALL_CYCLES(3), .FLUSH_CYCLES(2), .CNT_W(4)) u_b (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_redirect(ex_redirect),
    .dmem_ready(dmem_ready), .pc_write(pc_b), .ifid_write(ifw_b),
    .idex_bubble(bub_b), .ifid_flush(flu_b), .pipe_freeze(frz_b),
    .stall_cnt(sc_b), .flush_cnt(fc_b));

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: each instance owes a number of remaining stall and flush cycles.
  localparam int LU_N[2]  = '{1, 3};
  localparam int FL_N     = 2;
  localparam int CMAX[2]  = '{65535, 15};
  int stall_left[2], flush_left[2], scount[2], fcount[2];
  bit model_ok = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (model_ok || rst) begin
        for (int k = 0; k < 2; k++) begin
          int a_pc, a_ifw, a_bub, a_flu, a_frz, a_sc, a_fc;
          int e_pc, e_ifw, e_bub, e_frz;
          bit lu;
          string nm;
          nm    = (k == 0) ? "A" : "B";
          a_pc  = (k == 0) ? int'(pc_a)  : int'(pc_b);
          a_ifw = (k == 0) ? int'(ifw_a) : int'(ifw_b);
          a_bub = (k == 0) ? int'(bub_a) : int'(bub_b);
          a_flu = (k == 0) ? int'(flu_a) : int'(flu_b);
          a_frz = (k == 0) ? int'(frz_a) : int'(frz_b);
          a_sc  = (k == 0) ? int'(sc_a)  : int'(sc_b);
          a_fc  = (k == 0) ? int'(fc_a)  : int'(fc_b);
          lu = ex_mem_read && ex_rt != 0 &&
               (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
          e_pc = 1; e_ifw = 1; e_bub = 0; e_frz = 0;
          if (!rst) begin
            chk({"ifid_flush_", nm}, a_flu, int'(flush_left[k] > 0));
            chk({"stall_cnt_", nm}, a_sc, scount[k]);
            chk({"flush_cnt_", nm}, a_fc, fcount[k]);
          end
          if (rst) begin
            stall_left[k] = 0; flush_left[k] = 0; scount[k] = 0; fcount[k] = 0;
          end else if (!dmem_ready) begin
            e_pc = 0; e_ifw = 0; e_frz = 1;
          end else if (ex_redirect) begin
            e_bub = 1;
            flush_left[k] = FL_N;
            stall_left[k] = 0;
            if (fcount[k] < CMAX[k]) fcount[k]++;
          end else if (flush_left[k] > 0) begin
            e_bub = 1;
            flush_left[k]--;
          end else if (stall_left[k] > 0 || lu) begin
            e_pc = 0; e_ifw = 0; e_bub = 1;
            if (stall_left[k] > 0) stall_left[k]--;
            else stall_left[k] = LU_N[k] - 1;
            if (scount[k] < CMAX[k]) scount[k]++;
          end
          chk({"pc_write_", nm}, a_pc, e_pc);
          chk({"ifid_write_", nm}, a_ifw, e_ifw);
          chk({"idex_bubble_", nm}, a_bub, e_bub);
          chk({"pipe_freeze_", nm}, a_frz, e_frz);
        end
        if (rst) model_ok = 1;
      end
    end
  end

  logic snap_pc_a, snap_bub_a, snap_flu_a, snap_pc_b, snap_bub_b, snap_flu_b, snap_frz_b;

  task automatic step(input logic r, input logic mr, input logic [4:0] ert,
                      input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                      input logic redir, input logic rdy);
    rst = r; ex_mem_read = mr; ex_rt = ert; id_rs = rs; id_rt = rt;
    id_uses_rt = urt; ex_redirect = redir; dmem_ready = rdy;
    @(negedge clk);
    snap_pc_a = pc_a; snap_bub_a = bub_a; snap_flu_a = flu_a;
    snap_pc_b = pc_b; snap_bub_b = bub_b; snap_flu_b = flu_b; snap_frz_b = frz_b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, rdy);
  endtask

  task automatic hazard();
    step(1'b0, 1'b1, 5'd5, 5'd5, 5'd9, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    int nonadv, frz_n;
    rst = 1'b1; id_rs = 0; id_rt = 0; ex_rt = 0;
    id_uses_rt = 0; ex_mem_read = 0; ex_redirect = 0; dmem_ready = 1;
    @(posedge clk); #1;

    // Reset
    do_reset();
    chk("rst_pc_write", snap_pc_a, 1);
    chk("rst_stall_cnt", sc_a, 0);
    chk("rst_flush_cnt", fc_a, 0);
    chk("rst_ifid_flush", flu_a, 0);

    // Load-use on the single-cycle instance, then non-hazard variants
    hazard();
    chk("lu_pc_write", snap_pc_a, 0);
    chk("lu_bubble", snap_bub_a, 1);
    idle(1'b1);
    chk("lu_one_cycle_only", snap_pc_a, 1);
    chk("lu_stall_cnt", sc_a, 1);
    step(1'b0, 1'b1, 5'd0, 5'd0, 5'd9, 1'b0, 1'b0, 1'b1);
    chk("lu_rt0_no_stall", snap_pc_a, 1);
    step(1'b0, 1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 1'b1);
    chk("lu_rt_unused_no_stall", snap_pc_a, 1);
    step(1'b0, 1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0, 1'b1);
    chk("lu_rt_used_stall", snap_pc_a, 0);
    idle(1'b1);
    chk("lu_stall_cnt2", sc_a, 2);

    // Redirect coinciding with a load-use hazard
    do_reset();
    step(1'b0, 1'b1, 5'd5, 5'd5, 5'd9, 1'b0, 1'b1, 1'b1);
    chk("redir_bubble", snap_bub_a, 1);
    chk("redir_pc_write", snap_pc_a, 1);
    chk("redir_flush_same_cycle", snap_flu_a, 0);
    idle(1'b1);
    chk("flush_cycle1", snap_flu_a, 1);
    idle(1'b1);
    chk("flush_cycle2", snap_flu_a, 1);
    idle(1'b1);
    chk("flush_done", snap_flu_a, 0);
    chk("redir_flush_cnt", fc_a, 1);
    chk("redir_stall_cnt", sc_a, 0);

    // Freeze in the second cycle of a 3-cycle stall
    do_reset();
    nonadv = 0; frz_n = 0;
    hazard();          nonadv += !snap_pc_b; frz_n += snap_frz_b;
    idle(1'b0);        nonadv += !snap_pc_b; frz_n += snap_frz_b;
    idle(1'b0);        nonadv += !snap_pc_b; frz_n += snap_frz_b;
    idle(1'b1);        nonadv += !snap_pc_b; frz_n += snap_frz_b;
    idle(1'b1);        nonadv += !snap_pc_b; frz_n += snap_frz_b;
    idle(1'b1);        nonadv += !snap_pc_b; frz_n += snap_frz_b;
    chk("freeze_nonadvance", nonadv, 5);
    chk("freeze_cycles", frz_n, 2);
    chk("freeze_stall_cnt", sc_b, 3);

    // Redirect while the 3-cycle instance is in STALL
    do_reset();
    hazard();
    step(1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1, 1'b1);
    chk("stall_redir_pc_write", snap_pc_b, 1);
    chk("stall_redir_bubble", snap_bub_b, 1);
    idle(1'b1);
    chk("stall_redir_flush", snap_flu_b, 1);
    chk("stall_redir_pc_next", snap_pc_b, 1);
    chk("stall_redir_flush_cnt", fc_b, 1);
    chk("stall_redir_stall_cnt", sc_b, 1);

    // Counter saturation on the 4-bit instance
    do_reset();
    for (int i = 0; i < 20; i++) begin
      hazard();
      idle(1'b1);
      idle(1'b1);
    end
    chk("sat_stall_cnt_b", sc_b, 15);
    chk("sat_stall_cnt_a", sc_a, 20);

    // Reset in the middle of a flush aborts it
    step(1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1, 1'b1);
    idle(1'b1);
    do_reset();
    chk("rst_mid_flush", flu_b, 0);
    chk("rst_mid_flush_cnt", fc_b, 0);
    idle(1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
